quan_e_load_ctrl: RTL

- Sequences the quantisation E-scale register file. It fetches E words from the on-chip E buffer and issues the matching E_set, E_word, E_reg_start and E_reg_size writes for mode 0 or mode 1.
- It then steps next_out_sa_row_idx through 1..ROW_NUM_IN_SA while the output stage drains the SA rows.
- It sits between the tile scheduler (start, quan_start) and the E register file. It interlocks the two phases so that E_tile is never overwritten during a drain.

---
 rtl/quan_e_load_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/quan_e_load_ctrl.sv
// E-scale register file load sequencer plus SA row-drain index stepper.
// The two FSMs interlock so E registers never change while rows drain.
module quan_e_load_ctrl #(
  parameter int unsigned ROW_NUM_IN_SA = 16,
  parameter int unsigned E_WORD_WIDTH  = 512,
  parameter int unsigned ADDR_W        = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              mode_in,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    E_rd_en,
  output logic [ADDR_W-1:0]       E_rd_addr,
  input  logic                    E_rd_valid,
  input  logic [E_WORD_WIDTH-1:0] E_rd_data,
  output logic                    E_set,
  output logic [E_WORD_WIDTH-1:0] E_word,
  output logic [7:0]              E_reg_start,
  output logic [7:0]              E_reg_size,
  output logic [3:0]              mode,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_err,
  input  logic                    quan_start,
  input  logic                    quan_stall,
  output logic [5:0]              next_out_sa_row_idx,
  output logic                    quan_done
);

  localparam int unsigned IDX_W = 6;

  typedef enum logic [2:0] {L_IDLE, L_REQ, L_WAIT, L_WRITE, L_DONE} l_state_t;
  typedef enum logic {Q_IDLE, Q_RUN} q_state_t;

  l_state_t l_state, l_state_nxt;
  q_state_t q_state, q_state_nxt;

  logic [ADDR_W-1:0]       addr, addr_nxt;
  logic [1:0]              word_cnt, word_cnt_nxt;
  logic                    rd_en_nxt;
  logic [ADDR_W-1:0]       rd_addr_nxt;
  logic                    set_nxt;
  logic [E_WORD_WIDTH-1:0] word_nxt;
  logic [7:0]              reg_start_nxt, reg_size_nxt;
  logic [3:0]              mode_nxt;
  logic                    busy_nxt, load_done_nxt, load_err_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic                    quan_done_nxt;

  logic [7:0] reg_size_c;
  logic [1:0] last_word_c;

  // Mode 0 packs 32 x 16-bit E per word (2 words); mode 1 packs 16 sets (4 words)
  assign reg_size_c  = (mode == 4'd0) ? 8'd32 : 8'd16;
  assign last_word_c = (mode == 4'd0) ? 2'd1 : 2'd3;

  // Load FSM next-state and registered-output values
  always_comb begin
    l_state_nxt   = l_state;
    addr_nxt      = addr;
    word_cnt_nxt  = word_cnt;
    rd_en_nxt     = 1'b0;
    rd_addr_nxt   = E_rd_addr;
    set_nxt       = 1'b0;
    word_nxt      = E_word;
    reg_start_nxt = E_reg_start;
    reg_size_nxt  = E_reg_size;
    mode_nxt      = mode;
    busy_nxt      = busy;
    load_done_nxt = 1'b0;
    load_err_nxt  = 1'b0;
    unique case (l_state)
      L_IDLE: begin
        if (start && (q_state == Q_IDLE)) begin
          if (mode_in <= 4'd1) begin
            mode_nxt     = mode_in;
            addr_nxt     = base_addr;
            word_cnt_nxt = 2'd0;
            busy_nxt     = 1'b1;
            rd_en_nxt    = 1'b1;
            rd_addr_nxt  = base_addr;
            l_state_nxt  = L_REQ;
          end else begin
            load_err_nxt = 1'b1;
          end
        end
      end
      L_REQ: l_state_nxt = L_WAIT;
      L_WAIT: begin
        if (E_rd_valid) begin
          word_nxt      = E_rd_data;
          set_nxt       = 1'b1;
          reg_size_nxt  = reg_size_c;
          reg_start_nxt = 8'd1 + 8'(word_cnt) * reg_size_c;
          l_state_nxt   = L_WRITE;
        end
      end
      L_WRITE: begin
        addr_nxt     = addr + ADDR_W'(1);
        word_cnt_nxt = word_cnt + 2'd1;
        if (word_cnt == last_word_c) begin
          busy_nxt      = 1'b0;
          load_done_nxt = 1'b1;
          l_state_nxt   = L_DONE;
        end else begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = addr + ADDR_W'(1);
          l_state_nxt = L_REQ;
        end
      end
      L_DONE: l_state_nxt = L_IDLE;
      default: l_state_nxt = L_IDLE;
    endcase
  end

  // Drain FSM: start has priority over quan_start in a shared idle cycle
  always_comb begin
    q_state_nxt   = q_state;
    idx_nxt       = next_out_sa_row_idx;
    quan_done_nxt = 1'b0;
    unique case (q_state)
      Q_IDLE: begin
        if (quan_start && (l_state == L_IDLE) && !start) begin
          idx_nxt     = IDX_W'(1);
          q_state_nxt = Q_RUN;
        end
      end
      Q_RUN: begin
        if (!quan_stall) begin
          if (next_out_sa_row_idx == IDX_W'(ROW_NUM_IN_SA)) begin
            idx_nxt       = '0;
            quan_done_nxt = 1'b1;
            q_state_nxt   = Q_IDLE;
          end else begin
            idx_nxt = next_out_sa_row_idx + IDX_W'(1);
          end
        end
      end
      default: q_state_nxt = Q_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_state             <= L_IDLE;
      q_state             <= Q_IDLE;
      addr                <= '0;
      word_cnt            <= '0;
      E_rd_en             <= 1'b0;
      E_rd_addr           <= '0;
      E_set               <= 1'b0;
      E_word              <= '0;
      E_reg_start         <= '0;
      E_reg_size          <= '0;
      mode                <= '0;
      busy                <= 1'b0;
      load_done           <= 1'b0;
      load_err            <= 1'b0;
      next_out_sa_row_idx <= '0;
      quan_done           <= 1'b0;
    end else begin
      l_state             <= l_state_nxt;
      q_state             <= q_state_nxt;
      addr                <= addr_nxt;
      word_cnt            <= word_cnt_nxt;
      E_rd_en             <= rd_en_nxt;
      E_rd_addr           <= rd_addr_nxt;
      E_set               <= set_nxt;
      E_word              <= word_nxt;
      E_reg_start         <= reg_start_nxt;
      E_reg_size          <= reg_size_nxt;
      mode                <= mode_nxt;
      busy                <= busy_nxt;
      load_done           <= load_done_nxt;
      load_err            <= load_err_nxt;
      next_out_sa_row_idx <= idx_nxt;
      quan_done           <= quan_done_nxt;
    end
  end

endmodule
